// File: rtl/dmem_pkg.sv
// Shared constants for the byte-addressed data memory: access-size encodings and data width.
package dmem_pkg;

    localparam int DMEM_WORD_BITS = 32;

    localparam logic [1:0] MODE_WORD    = 2'b00;
    localparam logic [1:0] MODE_HALF    = 2'b01;
    localparam logic [1:0] MODE_BYTE    = 2'b10;
    localparam logic [1:0] MODE_INVALID = 2'b11;

endpackage

// File: rtl/dmem_lane_decode.sv
// Decodes access size and low address bits into a valid flag and a byte-lane enable.
// Lane i is the byte at addr+i; misaligned or invalid accesses enable no lanes.
module dmem_lane_decode
    import dmem_pkg::*;
(
    input  logic [1:0] addr_low,
    input  logic [1:0] rw_mode,
    output logic       valid,
    output logic [3:0] lane_en
);

    always_comb begin
        valid   = 1'b0;
        lane_en = 4'b0000;
        case (rw_mode)
            MODE_WORD: begin
                if (addr_low == 2'b00) begin
                    valid   = 1'b1;
                    lane_en = 4'b1111;
                end
            end
            MODE_HALF: begin
                if (!addr_low[0]) begin
                    valid   = 1'b1;
                    lane_en = 4'b0011;
                end
            end
            MODE_BYTE: begin
                valid   = 1'b1;
                lane_en = 4'b0001;
            end
            default: begin
                valid   = 1'b0;
                lane_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Little-endian byte-array data memory with combinational reads and sized, aligned writes.
// Optional macro DMEM_ACCESS_ERR_EN adds an 'err' output flagging invalid accesses.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DMEM_DATA_WIDTH = DMEM_WORD_BITS,
    parameter int DMEM_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [1:0]                 rw_mode,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr,
    input  logic [DMEM_DATA_WIDTH-1:0] w_data,
    output logic [DMEM_DATA_WIDTH-1:0] r_data
`ifdef DMEM_ACCESS_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int DEPTH = 2 ** DMEM_ADDR_WIDTH;

    logic [7:0]                 mem [DEPTH];
    logic                       access_valid;
    logic [3:0]                 lane_en;
    logic [DMEM_ADDR_WIDTH-1:0] lane_addr [4];

    dmem_lane_decode u_lane_decode (
        .addr_low (addr[1:0]),
        .rw_mode  (rw_mode),
        .valid    (access_valid),
        .lane_en  (lane_en)
    );

    // Aligned valid accesses never cross the top of memory, so the natural
    // truncation here only matters for lanes that are disabled anyway.
    for (genvar g = 0; g < 4; g++) begin : g_lane_addr
        assign lane_addr[g] = addr + DMEM_ADDR_WIDTH'(g);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en && access_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[lane_addr[i]] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Disabled lanes read as zero, which also yields zero for invalid accesses.
    always_comb begin
        r_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                r_data[8*i +: 8] = mem[lane_addr[i]];
            end
        end
    end

`ifdef DMEM_ACCESS_ERR_EN
    assign err = !access_valid;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized scoreboard bench for data_memory; expectations queued at drive time.
module tb_data_memory;

    localparam logic [1:0] M_WORD = 2'b00;
    localparam logic [1:0] M_HALF = 2'b01;
    localparam logic [1:0] M_BYTE = 2'b10;
    localparam logic [1:0] M_BAD  = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  rw_mode;
    logic [3:0]  addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
`ifdef DMEM_ACCESS_ERR_EN
    logic        err;
`endif

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_mem [16];

    data_memory #(
        .DMEM_DATA_WIDTH (32),
        .DMEM_ADDR_WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .rw_mode (rw_mode),
        .addr    (addr),
        .w_data  (w_data),
        .r_data  (r_data)
`ifdef DMEM_ACCESS_ERR_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic access_bad(input logic [1:0] mode, input logic [3:0] a);
        return (mode == M_BAD) || (mode == M_HALF && a[0]) || (mode == M_WORD && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] mode, input logic [3:0] a);
        int b;
        b = int'(a);
        if (access_bad(mode, a)) return 32'h0;
        case (mode)
            M_WORD:  return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
            M_HALF:  return {16'h0, model_mem[b+1], model_mem[b]};
            default: return {24'h0, model_mem[b]};
        endcase
    endfunction

    task automatic model_write(input logic [1:0] mode, input logic [3:0] a, input logic [31:0] wd);
        int n;
        n = (mode == M_WORD) ? 4 : (mode == M_HALF) ? 2 : 1;
        if (!access_bad(mode, a)) begin
            for (int i = 0; i < n; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [1:0] mode, input logic [3:0] a,
                                  input logic [31:0] wd, input string tag, input logic [31:0] exp_data);
        exp_t e;
        wr_en   = we;
        rw_mode = mode;
        addr    = a;
        w_data  = wd;
        e.tag   = tag;
        e.data  = exp_data;
        e.err   = access_bad(mode, a);
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (r_data === e.data) else begin
            errors++;
            $error("[TB] FAIL %s r_data observed=%h expected=%h", e.tag, r_data, e.data);
        end
`ifdef DMEM_ACCESS_ERR_EN
        checks++;
        assert (err === e.err) else begin
            errors++;
            $error("[TB] FAIL %s_err err observed=%b expected=%b", e.tag, err, e.err);
        end
`endif
    endtask

    task automatic step(input logic we, input logic [1:0] mode, input logic [3:0] a,
                        input logic [31:0] wd, input string tag, input logic [31:0] exp_data);
        @(negedge clk);
        apply_stimulus(we, mode, a, wd, tag, exp_data);
        check_output();
    endtask

    initial begin
        logic [1:0]  rm;
        logic [3:0]  ra;
        logic [31:0] rd;

        rst = 1'b0; wr_en = 1'b0; rw_mode = M_WORD; addr = 4'd0; w_data = 32'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        step(1'b0, M_WORD, 4'd0, 32'h0, "rst_word0", 32'h0);
        step(1'b0, M_HALF, 4'd0, 32'h0, "rst_half0", 32'h0);
        step(1'b0, M_BYTE, 4'd0, 32'h0, "rst_byte0", 32'h0);
        step(1'b0, M_BAD,  4'd0, 32'h0, "rst_bad0",  32'h0);

        step(1'b1, M_BYTE, 4'd5, 32'd15, "wr_b5_nofwd", 32'h0);
        step(1'b0, M_BYTE, 4'd5, 32'h0, "rd_b5", 32'h0000000F);
        step(1'b0, M_WORD, 4'd4, 32'h0, "rd_w4_a", 32'h00000F00);

        step(1'b1, M_HALF, 4'd7, 32'h1B181512, "wr_h7_bad", 32'h0);
        step(1'b0, M_BYTE, 4'd7, 32'h0, "rd_b7", 32'h0);
        step(1'b1, M_HALF, 4'd6, 32'h1B181512, "wr_h6_nofwd", 32'h0);
        step(1'b0, M_HALF, 4'd6, 32'h0, "rd_h6", 32'h00001512);
        step(1'b0, M_WORD, 4'd4, 32'h0, "rd_w4_b", 32'h15120F00);

        step(1'b1, M_WORD, 4'd6, 32'h211E1B18, "wr_w6_bad", 32'h0);
        step(1'b0, M_HALF, 4'd6, 32'h0, "rd_h6_kept", 32'h00001512);
        step(1'b1, M_WORD, 4'd8, 32'h211E1B18, "wr_w8_nofwd", 32'h0);
        step(1'b0, M_WORD, 4'd8, 32'h0, "rd_w8", 32'h211E1B18);
        step(1'b0, M_BYTE, 4'd11, 32'h0, "rd_b11", 32'h00000021);
        step(1'b0, M_HALF, 4'd10, 32'h0, "rd_h10", 32'h0000211E);

        step(1'b1, M_BAD, 4'd0, 32'hFFFFFFFF, "wr_bad_mode", 32'h0);
        step(1'b0, M_WORD, 4'd0, 32'h0, "rd_w0_kept", 32'h0);

        model_mem[5] = 8'h0F; model_mem[6] = 8'h12; model_mem[7] = 8'h15;
        model_mem[8] = 8'h18; model_mem[9] = 8'h1B; model_mem[10] = 8'h1E; model_mem[11] = 8'h21;
        for (int i = 0; i < 6; i++) begin
            ra = 4'(i * 4);
            step(1'b0, M_WORD, ra, $urandom, "idle_rd", model_read(M_WORD, ra));
        end
        step(1'b0, M_WORD, 4'd4, 32'h0, "idle_w4", 32'h15120F00);
        step(1'b0, M_WORD, 4'd8, 32'h0, "idle_w8", 32'h211E1B18);

        // Reset lands mid-cycle while a word write is being held.
        step(1'b1, M_WORD, 4'd8, 32'hABCD1234, "pre_rst_w8", 32'h211E1B18);
        #2;
        rst = 1'b0;
        apply_stimulus(1'b1, M_WORD, 4'd8, 32'hABCD1234, "rst_now_w8", 32'h0);
        check_output();
        apply_stimulus(1'b1, M_WORD, 4'd4, 32'hABCD1234, "rst_now_w4", 32'h0);
        check_output();
        @(posedge clk);
        apply_stimulus(1'b1, M_WORD, 4'd4, 32'hABCD1234, "rst_held_w4", 32'h0);
        check_output();
        step(1'b1, M_WORD, 4'd8, 32'hABCD1234, "rst_held_w8", 32'h0);

        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, M_WORD, 4'd12, 32'hCAFEF00D, "post_rst_wr", 32'h0);
        check_output();
        step(1'b0, M_WORD, 4'd12, 32'h0, "post_rst_w12", 32'hCAFEF00D);
        step(1'b0, M_WORD, 4'd8, 32'h0, "post_rst_w8", 32'h0);

        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_write(M_WORD, 4'd12, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rd = $urandom;
            step(1'b1, rm, ra, rd, "rand_wr", model_read(rm, ra));
            model_write(rm, ra, rd);
            step(1'b0, rm, ra, 32'h0, "rand_rd", model_read(rm, ra));
        end
        for (int i = 0; i < 4; i++) begin
            ra = 4'(i * 4);
            step(1'b0, M_WORD, ra, 32'h0, "final_rd", model_read(M_WORD, ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DMEM_DATA_WIDTH, default 32, data port width in bits; only 32 is supported.
REQ-002 Parameter DMEM_ADDR_WIDTH, default 4, byte-address width; capacity is 2**DMEM_ADDR_WIDTH bytes.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 wr_en  input  1  write enable; 1 = write at next rising clk edge.
REQ-006 rw_mode  input  2  access size: 00 word, 01 halfword, 10 byte, 11 invalid.
REQ-007 addr  input  DMEM_ADDR_WIDTH  byte address of access.
REQ-008 w_data  input  DMEM_DATA_WIDTH  write data; byte uses bits [7:0], halfword uses [15:0], word uses [31:0].
REQ-009 r_data  output  DMEM_DATA_WIDTH  read data for the current addr and rw_mode.

Function
REQ-010 Storage SHALL be a byte array of 2**DMEM_ADDR_WIDTH entries, little-endian: the lowest byte of a value sits at the lowest address.
REQ-011 Alignment: byte is always valid; halfword is valid only when addr[0]=0; word is valid only when addr[1:0]=00; rw_mode=11 is always invalid.
REQ-012 Read SHALL be combinational from addr, rw_mode and the array, with zero cycles of latency.
REQ-013 Byte read SHALL return {24'b0, mem[addr]}.
REQ-014 Halfword read SHALL return {16'b0, mem[addr+1], mem[addr]}.
REQ-015 Word read SHALL return {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}.
REQ-016 Read of an invalid access SHALL return 32'h0; reads never modify state.
REQ-017 On a rising clk edge with wr_en=1 and a valid access, exactly the addressed 1/2/4 bytes SHALL be written from the low bytes of w_data; all other bytes are unchanged.
REQ-018 Writes with wr_en=1 and an invalid access SHALL be ignored, leaving memory unchanged.
REQ-019 r_data SHALL reflect newly written bytes combinationally after the write edge, with no forwarding of write data within the same cycle.
REQ-020 The address space does not wrap: a valid aligned access never crosses the top of memory, so no wrap-around handling is required.

Reset
REQ-021 While rst=0, all bytes SHALL be cleared to 8'h00 asynchronously, and r_data SHALL be 32'h0 for any valid access.
REQ-022 Reset SHALL take priority over a simultaneous write; a write in progress when reset asserts is discarded.
REQ-023 After rst deasserts, normal writes SHALL resume at the first subsequent rising clk edge.

Configuration
REQ-024 Macro DMEM_ACCESS_ERR_EN, when defined, SHALL add output port err (1 bit).
REQ-025 With the macro defined, err is combinational and equals 1 whenever the current access is invalid (REQ-011), regardless of wr_en.
REQ-026 Without the macro, no err port exists, and behaviour is otherwise identical.

Structure
REQ-027 A shared package dmem_pkg SHALL hold the rw_mode encoding constants (MODE_WORD=2'b00, MODE_HALF=2'b01, MODE_BYTE=2'b10) and the data-width constant 32.
REQ-028 One sub-module, dmem_lane_decode, SHALL decode addr[1:0] and rw_mode into a valid flag and a 4-bit byte-lane enable; it is used by both the read and the write paths.

Verification
REQ-029 Reset, then word/halfword/byte reads at addr 0 with wr_en=0 -> r_data=0; rw_mode=11 -> r_data=0 (err=1 if enabled).
REQ-030 Byte write w_data=15 at addr 5 -> byte read at 5 returns 32'h0000000F; word read at 4 returns 32'h00000F00.
REQ-031 Halfword write 32'h1B181512 at addr 7 -> ignored, byte 7 stays 0; the same write at addr 6 -> halfword read at 6 returns 32'h00001512.
REQ-032 Word write 32'h211E1B18 at addr 6 -> ignored; the same write at addr 8 -> word read at 8 returns 32'h211E1B18, and byte read at 11 returns 32'h00000021.
REQ-033 Drive rst=0 after the writes above (asynchronously, mid-cycle) -> reads at addrs 4 and 8 return 0 immediately; a write held with wr_en=1 during reset does not take effect.
REQ-034 Drive wr_en=0 with changing addr and w_data for several cycles -> memory contents are unchanged.
